// File: rtl/pcie_pgtb_dpram.sv
// ============================================================================
// Module   : pcie_pgtb_dpram
// Brief    : True dual-port page-table buffer with two pipelined Avalon-MM
//            slaves, s1-wins write collision handling and optional zero-fill.
//            Optional macro PGTB_DPRAM_OUTREG_EN adds a read output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_pgtb_dpram #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 19,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,
    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic                  s1_waitrequest,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    input  logic [ADDR_W-1:0]     s2_address,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [DATA_W/8-1:0]   s2_byteenable,
    input  logic [DATA_W-1:0]     s2_writedata,
    output logic                  s2_waitrequest,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid,
    output logic                  clear_done
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d, rdata2_q, rdata2_d;
    logic                rvalid1_q, rvalid1_d, rvalid2_q, rvalid2_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                stall, collide, clearing;
    logic                s1_acc, s2_acc;
    logic                p1_we, p2_we;
    logic [ADDR_W-1:0]   p1_addr;
    logic [DATA_W-1:0]   p1_wdata;
    logic [BE_W-1:0]     p1_be;

    always_comb begin
        stall          = reset | reset_req | (state_q != ST_RUN);
        collide        = s1_write & s2_write & (s1_address == s2_address);
        s1_waitrequest = stall;
        // s1 wins a same-address write race; s2 retries on the next cycle
        s2_waitrequest = stall | collide;
        s1_acc         = (s1_read | s1_write) & ~s1_waitrequest;
        s2_acc         = (s2_read | s2_write) & ~s2_waitrequest;
        clearing       = (state_q == ST_CLEAR) & ~reset_req & ~reset;
        clear_done     = (state_q == ST_RUN) & ~reset;

        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (clearing) begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end

        // Zero-fill borrows port 1 of the array while the slaves are stalled
        p1_we    = clearing | (s1_acc & s1_write);
        p1_addr  = clearing ? clr_cnt_q : s1_address;
        p1_wdata = clearing ? '0 : s1_writedata;
        p1_be    = clearing ? '1 : s1_byteenable;
        p2_we    = s2_acc & s2_write;

        rvalid1_d = s1_acc & s1_read & ~s1_write;
        rvalid2_d = s2_acc & s2_read & ~s2_write;
        rdata1_d  = rvalid1_d ? mem[s1_address] : rdata1_q;
        rdata2_d  = rvalid2_d ? mem[s2_address] : rdata2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= '0;
            rvalid1_q <= 1'b0;
            rvalid2_q <= 1'b0;
            rdata1_q  <= '0;
            rdata2_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rvalid1_q <= rvalid1_d;
            rvalid2_q <= rvalid2_d;
            rdata1_q  <= rdata1_d;
            rdata2_q  <= rdata2_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (p1_we && p1_be[b]) begin
                mem[p1_addr][b*8 +: 8] <= p1_wdata[b*8 +: 8];
            end
            if (p2_we && s2_byteenable[b]) begin
                mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
            end
        end
    end

`ifdef PGTB_DPRAM_OUTREG_EN
    logic [DATA_W-1:0] out1_data_q, out2_data_q;
    logic              out1_valid_q, out2_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out1_data_q  <= '0;
            out2_data_q  <= '0;
            out1_valid_q <= 1'b0;
            out2_valid_q <= 1'b0;
        end else begin
            out1_data_q  <= rdata1_q;
            out2_data_q  <= rdata2_q;
            out1_valid_q <= rvalid1_q;
            out2_valid_q <= rvalid2_q;
        end
    end

    assign s1_readdata      = out1_data_q;
    assign s2_readdata      = out2_data_q;
    assign s1_readdatavalid = out1_valid_q;
    assign s2_readdatavalid = out2_valid_q;
`else
    assign s1_readdata      = rdata1_q;
    assign s2_readdata      = rdata2_q;
    assign s1_readdatavalid = rvalid1_q;
    assign s2_readdatavalid = rvalid2_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pcie_pgtb_dpram.sv
// ============================================================================
// Module   : tb_pcie_pgtb_dpram
// Brief    : Directed self-checking bench for pcie_pgtb_dpram (ADDR_W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcie_pgtb_dpram;

`ifdef PGTB_DPRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset, reset_req;
    logic [3:0]  s1_address, s2_address;
    logic        s1_read, s1_write, s2_read, s2_write;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic [31:0] s1_writedata, s2_writedata;
    logic        s1_waitrequest, s2_waitrequest;
    logic [31:0] s1_readdata, s2_readdata;
    logic        s1_readdatavalid, s2_readdatavalid;
    logic        clear_done;

    int tests = 0;
    int fails = 0;

    logic [31:0] q1[$];
    logic [31:0] q2[$];

    logic [3:0]  pipe_addr [4] = '{4'd5, 4'd3, 4'd7, 4'd0};
    logic [31:0] pipe_exp  [4] = '{32'h1122CCDD, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0};

    pcie_pgtb_dpram #(
        .DATA_W         (32),
        .ADDR_W         (4),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .reset_req        (reset_req),
        .s1_address       (s1_address),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_byteenable    (s1_byteenable),
        .s1_writedata     (s1_writedata),
        .s1_waitrequest   (s1_waitrequest),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .s2_address       (s2_address),
        .s2_read          (s2_read),
        .s2_write         (s2_write),
        .s2_byteenable    (s2_byteenable),
        .s2_writedata     (s2_writedata),
        .s2_waitrequest   (s2_waitrequest),
        .s2_readdata      (s2_readdata),
        .s2_readdatavalid (s2_readdatavalid),
        .clear_done       (clear_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (s1_readdatavalid) q1.push_back(s1_readdata);
        if (s2_readdatavalid) q2.push_back(s2_readdata);
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop1(input string tag, input logic [31:0] exp);
        int n = 0;
        while (q1.size() == 0 && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_present"}, 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) chk(tag, q1.pop_front(), exp);
    endtask

    task automatic pop2(input string tag, input logic [31:0] exp);
        int n = 0;
        while (q2.size() == 0 && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_present"}, 32'(q2.size() != 0), 32'd1);
        if (q2.size() != 0) chk(tag, q2.pop_front(), exp);
    endtask

    task automatic rd1(input logic [3:0] a, input logic [31:0] exp, input string tag);
        s1_address = a;
        s1_read    = 1'b1;
        #1;
        chk({tag, "_accept"}, 32'(s1_waitrequest), 32'd0);
        tick();
        s1_read = 1'b0;
        chk({tag, "_latency"}, 32'(s1_readdatavalid), 32'(LAT == 1));
        pop1(tag, exp);
    endtask

    task automatic rd2(input logic [3:0] a, input logic [31:0] exp, input string tag);
        s2_address = a;
        s2_read    = 1'b1;
        tick();
        s2_read = 1'b0;
        pop2(tag, exp);
    endtask

    // Counts cycles from reset release until clear_done, noting any early acceptance window
    task automatic measure_clear(input string tag);
        int n = 0;
        logic saw_ready = 1'b0;
        while (!clear_done && n < 40) begin
            if (!s1_waitrequest || !s2_waitrequest) saw_ready = 1'b1;
            tick();
            n++;
        end
        chk({tag, "_cycles"}, 32'(n), 32'd16);
        chk({tag, "_wait_held"}, 32'(saw_ready), 32'd0);
        chk({tag, "_ready_after"}, 32'(s1_waitrequest | s2_waitrequest), 32'd0);
    endtask

    initial begin
        reset = 1'b1; reset_req = 1'b0;
        s1_address = '0; s1_read = 1'b0; s1_write = 1'b0; s1_byteenable = '0; s1_writedata = '0;
        s2_address = '0; s2_read = 1'b0; s2_write = 1'b0; s2_byteenable = '0; s2_writedata = '0;
        tick(); tick(); tick();

        chk("rst_s1_wait",  32'(s1_waitrequest),   32'd1);
        chk("rst_s2_wait",  32'(s2_waitrequest),   32'd1);
        chk("rst_s1_rdv",   32'(s1_readdatavalid), 32'd0);
        chk("rst_s2_rdv",   32'(s2_readdatavalid), 32'd0);
        chk("rst_s1_rdata", s1_readdata,           32'h0);
        chk("rst_s2_rdata", s2_readdata,           32'h0);
        chk("rst_done",     32'(clear_done),       32'd0);

        reset = 1'b0;
        q1.delete(); q2.delete();
        measure_clear("clear1");

        for (int a = 0; a < 16; a++) rd1(4'(a), 32'h0, "clear_zero");

        // Partial-byte write on s2 over a full s1 write
        s1_address = 4'd5; s1_writedata = 32'h11223344; s1_byteenable = 4'b1111; s1_write = 1'b1;
        tick();
        s1_write = 1'b0;
        s2_address = 4'd5; s2_writedata = 32'hAABBCCDD; s2_byteenable = 4'b0011; s2_write = 1'b1;
        tick();
        s2_write = 1'b0;
        rd2(4'd5, 32'h1122CCDD, "byte_merge");

        // Same-address write collision
        s1_address = 4'd3; s1_writedata = 32'h0000FFFF; s1_byteenable = 4'b1111; s1_write = 1'b1;
        s2_address = 4'd3; s2_writedata = 32'hFFFF0000; s2_byteenable = 4'b1100; s2_write = 1'b1;
        #1;
        chk("coll_s2_wait", 32'(s2_waitrequest), 32'd1);
        chk("coll_s1_wait", 32'(s1_waitrequest), 32'd0);
        tick();
        s1_write = 1'b0;
        s1_read  = 1'b1;
        #1;
        chk("coll_s2_retry", 32'(s2_waitrequest), 32'd0);
        tick();
        s2_write = 1'b0;
        tick();
        s1_read = 1'b0;
        pop1("coll_rd_n1", 32'h0000FFFF);
        pop1("coll_rd_n2", 32'hFFFFFFFF);

        // Cross-port read during write returns old data
        s1_address = 4'd7; s1_writedata = 32'hDEADBEEF; s1_byteenable = 4'b1111; s1_write = 1'b1;
        s2_address = 4'd7; s2_read = 1'b1;
        tick();
        s1_write = 1'b0;
        tick();
        s2_read = 1'b0;
        pop2("rdw_old", 32'h0);
        pop2("rdw_new", 32'hDEADBEEF);

        // Pipelined reads followed by a freeze request
        q1.delete();
        for (int i = 0; i < 4; i++) begin
            s1_address = pipe_addr[i];
            s1_read    = 1'b1;
            #1;
            chk("pipe_accept", 32'(s1_waitrequest), 32'd0);
            tick();
        end
        s1_address = 4'd1;
        reset_req  = 1'b1;
        s2_address = 4'd0; s2_writedata = 32'h55555555; s2_byteenable = 4'b1111; s2_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("freeze_wait", 32'({s1_waitrequest, s2_waitrequest}), 32'd3);
            tick();
        end
        reset_req = 1'b0;
        s1_read   = 1'b0;
        s2_write  = 1'b0;
        tick(); tick(); tick();
        chk("pipe_count", 32'(q1.size()), 32'd4);
        for (int i = 0; i < 4; i++) pop1("pipe_data", pipe_exp[i]);
        rd1(4'd0, 32'h0, "freeze_no_write");

        // Reset in the middle of a clear restarts the fill from address 0
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("midclear_not_done", 32'(clear_done), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q1.delete(); q2.delete();
        measure_clear("clear2");
        rd1(4'd5, 32'h0, "reclear_5");
        rd2(4'd15, 32'h0, "reclear_15");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
